// File: rtl/bk_serial_unadder.sv
// bk_serial_unadder: bit-serial subtractor recovering B = S - A from a Brent-Kung sum S and addend A.
// Resolves DIGIT bits per cycle, LSB first, with valid/ready handshakes on input and output.
// Optional range check enabled by defining BK_UNADD_RANGE_CHECK_EN; without it out_err is tied to 0.
module bk_serial_unadder #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_addend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_operand,
  output logic             out_err
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("bk_serial_unadder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_add;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out_operand;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;

  logic [DIGIT:0]   w_d;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // One digit of S - A - borrow; the extra MSB is the outgoing borrow (sign of the digit difference).
  assign w_d = {1'b0, r_sum[DIGIT-1:0]} - {1'b0, r_add[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};

  // New digit enters from the MSB side so that after N shifts the LSB digit lands at bit 0.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_d[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(N - 1));

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = r_out_valid;
  assign out_operand = r_out_operand;

`ifdef BK_UNADD_RANGE_CHECK_EN
  logic r_top;
  logic r_out_err;
  assign out_err = r_out_err;
`else
  logic w_unused_top;
  assign w_unused_top = in_sum[WIDTH];
  assign out_err      = 1'b0;
`endif

  // Control FSM and serial datapath; outputs are registered and change only on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_sum         <= '0;
      r_add         <= '0;
      r_res         <= '0;
      r_out_operand <= '0;
      r_borrow      <= 1'b0;
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
`ifdef BK_UNADD_RANGE_CHECK_EN
      r_top         <= 1'b0;
      r_out_err     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sum    <= in_sum[WIDTH-1:0];
            r_add    <= in_addend;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef BK_UNADD_RANGE_CHECK_EN
            r_top    <= in_sum[WIDTH];
`endif
            r_state  <= StRun;
          end
        end
        StRun: begin
          r_sum    <= r_sum >> DIGIT;
          r_add    <= r_add >> DIGIT;
          r_res    <= w_res_next;
          r_borrow <= w_d[DIGIT];
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_operand <= w_res_next;
            r_out_valid   <= 1'b1;
`ifdef BK_UNADD_RANGE_CHECK_EN
            // Full result is 2^WIDTH*(top - borrow) + low; in range only when top == borrow.
            r_out_err     <= r_top ^ w_d[DIGIT];
`endif
            r_state       <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_serial_unadder.sv
// Directed bench for bk_serial_unadder: one DIGIT=1 instance and one DIGIT=4 instance.
// Expected out_err depends on whether BK_UNADD_RANGE_CHECK_EN is defined for the build.
module tb_bk_serial_unadder;

`ifdef BK_UNADD_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_out_err;
  logic [12:0] d1_in_sum;
  logic [11:0] d1_in_addend, d1_out_operand;

  logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_out_err;
  logic [12:0] d4_in_sum;
  logic [11:0] d4_in_addend, d4_out_operand;

  int total;
  int bad;

  bk_serial_unadder #(.WIDTH(12), .DIGIT(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (d1_in_valid),
    .in_ready    (d1_in_ready),
    .in_sum      (d1_in_sum),
    .in_addend   (d1_in_addend),
    .out_valid   (d1_out_valid),
    .out_ready   (d1_out_ready),
    .out_operand (d1_out_operand),
    .out_err     (d1_out_err)
  );

  bk_serial_unadder #(.WIDTH(12), .DIGIT(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (d4_in_valid),
    .in_ready    (d4_in_ready),
    .in_sum      (d4_in_sum),
    .in_addend   (d4_in_addend),
    .out_valid   (d4_out_valid),
    .out_ready   (d4_out_ready),
    .out_operand (d4_out_operand),
    .out_err     (d4_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one pair into the selected instance and returns the result and latency.
  // Latency counts the accepting cycle as cycle 1; -1 means out_valid never rose.
  task automatic do_op(input bit d4, input logic [12:0] s, input logic [11:0] a, input bit rdy,
                       output logic [11:0] op, output logic err, output int lat);
    int n;
    n = 0;
    while (!(d4 ? d4_in_ready : d1_in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (d4) begin
      d4_in_valid = 1'b1; d4_in_sum = s; d4_in_addend = a; d4_out_ready = rdy;
    end else begin
      d1_in_valid = 1'b1; d1_in_sum = s; d1_in_addend = a; d1_out_ready = rdy;
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    if (d4) begin
      d4_in_valid = 1'b0; d4_in_sum = ~s; d4_in_addend = ~a;
    end else begin
      d1_in_valid = 1'b0; d1_in_sum = ~s; d1_in_addend = ~a;
    end
    lat = -1;
    op  = '0;
    err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (d4 ? d4_out_valid : d1_out_valid) begin
        lat = k;
        op  = d4 ? d4_out_operand : d1_out_operand;
        err = d4 ? d4_out_err : d1_out_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (rdy && lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if (d1_out_valid !== 1'b0 || d1_out_operand !== 12'h000 || d1_out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_d1_outputs: got valid=%b op=%h err=%b, want 0 000 0",
               d1_out_valid, d1_out_operand, d1_out_err);
    end
    total++;
    if (d1_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_d1_in_ready: got %b want 1", d1_in_ready);
    end
    total++;
    if (d4_out_valid !== 1'b0 || d4_out_operand !== 12'h000 || d4_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_d4: got valid=%b op=%h ready=%b, want 0 000 1",
               d4_out_valid, d4_out_operand, d4_in_ready);
    end
  endtask

  task automatic test_basic;
    logic [11:0] op;
    logic        err;
    int          lat;
    do_op(1'b0, 13'h0579, 12'h123, 1'b1, op, err, lat);
    total++;
    if (op !== 12'h456 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got op=%h err=%b want 456 0", op, err);
    end
    total++;
    if (lat !== 13) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 13", lat);
    end
    // out_ready was already high, so the result went on its first valid cycle.
    total++;
    if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_consume: got valid=%b ready=%b want 0 1", d1_out_valid, d1_in_ready);
    end
  endtask

  task automatic test_extremes;
    logic [12:0] s_tab [4] = '{13'h1FFE, 13'h0000, 13'h1000, 13'h0ABC};
    logic [11:0] a_tab [4] = '{12'hFFF,  12'h001,  12'h000,  12'h0BC};
    logic [11:0] o_tab [4] = '{12'hFFF,  12'hFFF,  12'h000,  12'hA00};
    bit          e_tab [4] = '{1'b0,     1'b1,     1'b1,     1'b0};
    logic [11:0] op;
    logic        err;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, s_tab[i], a_tab[i], 1'b1, op, err, lat);
      total++;
      if (op !== o_tab[i] || err !== (RC & e_tab[i]) || lat !== 13) begin
        bad++;
        $display("FAIL extreme_%0d: got op=%h err=%b lat=%0d want %h %b 13",
                 i, op, err, lat, o_tab[i], RC & e_tab[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] op;
    logic        err;
    int          lat;
    do_op(1'b0, 13'h0ABC, 12'h0BC, 1'b0, op, err, lat);
    total++;
    if (op !== 12'hA00 || err !== 1'b0 || lat !== 13) begin
      bad++;
      $display("FAIL bp_first: got op=%h err=%b lat=%0d want A00 0 13", op, err, lat);
    end
    d1_in_valid  = 1'b1;
    d1_in_sum    = 13'h0FFF;
    d1_in_addend = 12'h000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (d1_out_valid !== 1'b1 || d1_out_operand !== 12'hA00 || d1_out_err !== 1'b0 ||
          d1_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b op=%h err=%b ready=%b want 1 A00 0 0",
                 c, d1_out_valid, d1_out_operand, d1_out_err, d1_in_ready);
      end
    end
    d1_in_valid  = 1'b0;
    d1_out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", d1_out_valid, d1_in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [11:0] op;
    logic        err;
    int          lat;
    d1_in_valid  = 1'b1;
    d1_in_sum    = 13'h0579;
    d1_in_addend = 12'h123;
    d1_out_ready = 1'b1;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1 || d1_out_operand !== 12'h000) begin
      bad++;
      $display("FAIL midrun_reset: got valid=%b ready=%b op=%h want 0 1 000",
               d1_out_valid, d1_in_ready, d1_out_operand);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 13'h0002, 12'h001, 1'b1, op, err, lat);
    total++;
    if (op !== 12'h001 || err !== 1'b0 || lat !== 13) begin
      bad++;
      $display("FAIL midrun_next: got op=%h err=%b lat=%0d want 001 0 13", op, err, lat);
    end
  endtask

  task automatic test_digit4;
    logic [11:0] op, a, b, exp_op;
    logic [12:0] s;
    logic        err, exp_err;
    int          lat, diff;
    do_op(1'b1, 13'h0579, 12'h123, 1'b1, op, err, lat);
    total++;
    if (op !== 12'h456 || err !== 1'b0 || lat !== 4) begin
      bad++;
      $display("FAIL d4_basic: got op=%h err=%b lat=%0d want 456 0 4", op, err, lat);
    end
    // Consistent pairs: S = A + B must give back B with no error.
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      s = {1'b0, a} + {1'b0, b};
      do_op(1'b1, s, a, 1'b1, op, err, lat);
      total++;
      if (op !== b || err !== 1'b0 || lat !== 4) begin
        bad++;
        $display("FAIL d4_sum_%0d: S=%h A=%h got op=%h err=%b lat=%0d want %h 0 4",
                 i, s, a, op, err, lat, b);
      end
    end
    // Arbitrary pairs against (S - A) mod 4096 and the range flag.
    for (int i = 0; i < 20; i++) begin
      a       = 12'($urandom);
      s       = 13'($urandom);
      diff    = int'(s) - int'(a);
      exp_op  = 12'(diff);
      exp_err = RC & ((diff < 0) || (diff > 4095));
      do_op(1'b1, s, a, 1'b1, op, err, lat);
      total++;
      if (op !== exp_op || err !== exp_err || lat !== 4) begin
        bad++;
        $display("FAIL d4_rand_%0d: S=%h A=%h got op=%h err=%b lat=%0d want %h %b 4",
                 i, s, a, op, err, lat, exp_op, exp_err);
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    d1_in_valid  = 1'b0;
    d1_in_sum    = '0;
    d1_in_addend = '0;
    d1_out_ready = 1'b1;
    d4_in_valid  = 1'b0;
    d4_in_sum    = '0;
    d4_in_addend = '0;
    d4_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_reset_mid_run;
    test_digit4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
